// File: rtl/read_req_gen.sv
// read_req_gen: round-robin arbiter over PU transfer requests that splits each
// accepted transfer into MAX_BURST-beat read requests, stalling on read_info_full.
module read_req_gen #(
    parameter int NUM_PU     = 1,
    parameter int D_TYPE_W   = 2,
    parameter int RD_SIZE_W  = 20,
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 256,
    parameter int DATA_BYTES = 8,
    parameter int PU_ID_W    = $clog2(NUM_PU) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PU-1:0]             pu_req_valid,
    output logic [NUM_PU-1:0]             pu_req_ready,
    input  logic [NUM_PU*ADDR_W-1:0]      pu_req_addr,
    input  logic [NUM_PU*RD_SIZE_W-1:0]   pu_req_size,
    input  logic [NUM_PU*D_TYPE_W-1:0]    pu_req_d_type,
    input  logic                          read_info_full,
    output logic                          rd_req,
    output logic [RD_SIZE_W-1:0]          rd_req_size,
    output logic [PU_ID_W-1:0]            rd_req_pu_id,
    output logic [D_TYPE_W-1:0]           rd_req_d_type,
    output logic [ADDR_W-1:0]             rd_req_addr,
    output logic [NUM_PU-1:0]             pu_done,
    output logic                          busy
);
    localparam logic [RD_SIZE_W-1:0] MB = RD_SIZE_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0]    DB = ADDR_W'(DATA_BYTES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [RD_SIZE_W-1:0]  r_rem;
    logic [D_TYPE_W-1:0]   r_dt;
    logic [PU_ID_W-1:0]    r_pu_id;
    logic [PU_ID_W-1:0]    r_last;
    logic [NUM_PU-1:0]     r_done;

    logic [PU_ID_W-1:0]    w_g;
    logic                  w_acc;
    logic [RD_SIZE_W-1:0]  w_chunk;
    logic [ADDR_W-1:0]     w_addr;
    logic [RD_SIZE_W-1:0]  w_size;
    logic [D_TYPE_W-1:0]   w_dt;
    int                    w_best;

    // Priority distance from last_grant+1; the smallest distance among valid PUs wins.
    always_comb begin
        w_best = NUM_PU;
        w_g    = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (pu_req_valid[k] && ((k + NUM_PU - 1 - int'(r_last)) % NUM_PU) < w_best) begin
                w_best = (k + NUM_PU - 1 - int'(r_last)) % NUM_PU;
                w_g    = PU_ID_W'(k);
            end
        end
    end

    assign w_acc   = (r_state == IDLE) && (w_best < NUM_PU) && !reset;
    assign w_addr  = pu_req_addr[w_g*ADDR_W +: ADDR_W];
    assign w_size  = pu_req_size[w_g*RD_SIZE_W +: RD_SIZE_W];
    assign w_dt    = pu_req_d_type[w_g*D_TYPE_W +: D_TYPE_W];
    assign w_chunk = (r_rem > MB) ? MB : r_rem;

    always_comb begin
        for (int k = 0; k < NUM_PU; k++) pu_req_ready[k] = w_acc && (w_g == PU_ID_W'(k));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_dt    <= '0;
            r_pu_id <= '0;
            r_last  <= PU_ID_W'(NUM_PU - 1);
            r_done  <= '0;
        end else begin
            r_done <= '0;
            if (r_state == IDLE) begin
                if (w_acc) begin
                    r_addr  <= w_addr;
                    r_rem   <= w_size;
                    r_dt    <= w_dt;
                    r_pu_id <= w_g;
                    r_last  <= w_g;
                    if (w_size == '0) r_done <= NUM_PU'(1) << w_g;
                    else r_state <= ISSUE;
                end
            end else if (!read_info_full) begin
                r_rem  <= r_rem - w_chunk;
                r_addr <= r_addr + ADDR_W'(w_chunk) * DB;
                if (r_rem == w_chunk) begin
                    r_done  <= NUM_PU'(1) << r_pu_id;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign rd_req        = (r_state == ISSUE) && !read_info_full;
    assign rd_req_size   = w_chunk;
    assign rd_req_addr   = r_addr;
    assign rd_req_pu_id  = r_pu_id;
    assign rd_req_d_type = r_dt;
    assign pu_done       = r_done;
    assign busy          = (r_state == ISSUE);
endmodule

// File: tb/tb_read_req_gen.sv
// tb_read_req_gen: table-driven cycle vectors plus hand sequences for
// arbitration fairness and reset during a multi-burst transfer.
module tb_read_req_gen;
    logic        clk;
    logic        reset;
    logic [1:0]  pu_req_valid;
    logic [1:0]  pu_req_ready;
    logic [63:0] pu_req_addr;
    logic [39:0] pu_req_size;
    logic [3:0]  pu_req_d_type;
    logic        read_info_full;
    logic        rd_req;
    logic [19:0] rd_req_size;
    logic [1:0]  rd_req_pu_id;
    logic [1:0]  rd_req_d_type;
    logic [31:0] rd_req_addr;
    logic [1:0]  pu_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    read_req_gen #(.NUM_PU(2)) dut (
        .clk(clk), .reset(reset),
        .pu_req_valid(pu_req_valid), .pu_req_ready(pu_req_ready),
        .pu_req_addr(pu_req_addr), .pu_req_size(pu_req_size), .pu_req_d_type(pu_req_d_type),
        .read_info_full(read_info_full),
        .rd_req(rd_req), .rd_req_size(rd_req_size), .rd_req_pu_id(rd_req_pu_id),
        .rd_req_d_type(rd_req_d_type), .rd_req_addr(rd_req_addr),
        .pu_done(pu_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v, a0, s0, a1, s1, full;
        logic [31:0] rdy, rd, sz, addr, pu, dt, done, bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ng;
        int lg;
        int exp_g[4];
        vec_t r;
        exp_g = '{0, 1, 0, 1};
        //          v  a0        s0   a1           s1   full rdy rd  sz   addr         pu dt done busy
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   0,           0, 0, 0,  0});
        tbl.push_back(vec_t'{1, 'h1000,   600, 0,           0,   0,   1,  0,  0,   0,           0, 0, 0,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'h1000,      0, 1, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'h1800,      0, 1, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  88,  'h2000,      0, 1, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'h22C0,      0, 1, 1,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'h22C0,      0, 1, 0,  0});
        tbl.push_back(vec_t'{2, 0,        0,   'h4000,      512, 0,   2,  0,  0,   'h22C0,      0, 1, 0,  0});
        for (int i = 0; i < 5; i++)
            tbl.push_back(vec_t'{0, 0,    0,   0,           0,   1,   0,  0,  256, 'h4000,      1, 2, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'h4000,      1, 2, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'h4800,      1, 2, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'h5000,      1, 2, 2,  0});
        tbl.push_back(vec_t'{1, 'h100,    0,   0,           0,   0,   1,  0,  0,   'h5000,      1, 2, 0,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'h100,       0, 1, 1,  0});
        tbl.push_back(vec_t'{1, 'h200,    256, 0,           0,   0,   1,  0,  0,   'h100,       0, 1, 0,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'h200,       0, 1, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'hA00,       0, 1, 1,  0});
        tbl.push_back(vec_t'{2, 0,        0,   'hFFFFF800,  512, 0,   2,  0,  0,   'hA00,       0, 1, 0,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 'hFFFFF800,  1, 2, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  256, 0,           1, 2, 0,  1});
        tbl.push_back(vec_t'{1, 'h3000,   1,   0,           0,   0,   1,  0,  0,   'h800,       1, 2, 2,  0});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  1,  1,   'h3000,      0, 1, 0,  1});
        tbl.push_back(vec_t'{0, 0,        0,   0,           0,   0,   0,  0,  0,   'h3008,      0, 1, 1,  0});

        pu_req_d_type  = {2'd2, 2'd1};
        pu_req_addr    = '0;
        pu_req_size    = '0;
        read_info_full = 1'b0;
        pu_req_valid   = 2'b11;
        reset          = 1'b1;
        tick();
        tick();
        #1;
        chk("reset_ready", 32'(pu_req_ready), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            r = tbl[i];
            pu_req_valid   = 2'(r.v);
            pu_req_addr    = {r.a1, r.a0};
            pu_req_size    = {20'(r.s1), 20'(r.s0)};
            read_info_full = r.full[0];
            #1;
            chk($sformatf("row%0d ready", i), 32'(pu_req_ready), r.rdy);
            chk($sformatf("row%0d rd_req", i), 32'(rd_req), r.rd);
            chk($sformatf("row%0d size", i), 32'(rd_req_size), r.sz);
            chk($sformatf("row%0d addr", i), rd_req_addr, r.addr);
            chk($sformatf("row%0d pu_id", i), 32'(rd_req_pu_id), r.pu);
            chk($sformatf("row%0d d_type", i), 32'(rd_req_d_type), r.dt);
            chk($sformatf("row%0d done", i), 32'(pu_done), r.done);
            chk($sformatf("row%0d busy", i), 32'(busy), r.bsy);
            tick();
        end

        // Arbitration: both PUs held valid with single-beat transfers.
        pu_req_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pu_req_valid = 2'b11;
        pu_req_addr  = {32'h20, 32'h10};
        pu_req_size  = {20'd1, 20'd1};
        ng = 0;
        lg = -1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("arb_onehot", 32'($countones(pu_req_ready) <= 1), 1);
            if (rd_req) chk("arb_pu_id", 32'(rd_req_pu_id), 32'(lg));
            if (pu_req_ready != 2'b00) begin
                lg = pu_req_ready[1] ? 1 : 0;
                if (ng < 4) chk($sformatf("arb_grant%0d", ng), 32'(lg), 32'(exp_g[ng]));
                ng++;
            end
            tick();
        end
        chk("arb_count", 32'(ng >= 4), 1);

        // Reset during the second of four bursts.
        pu_req_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pu_req_valid = 2'b01;
        pu_req_addr  = '0;
        pu_req_size  = {20'd0, 20'd1024};
        #1;
        chk("rst_accept", 32'(pu_req_ready), 1);
        tick();
        pu_req_valid = 2'b00;
        #1;
        chk("rst_b1_rd", 32'(rd_req), 1);
        chk("rst_b1_addr", rd_req_addr, 0);
        tick();
        #1;
        chk("rst_b2_rd", 32'(rd_req), 1);
        chk("rst_b2_addr", rd_req_addr, 'h800);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_after_rd", 32'(rd_req), 0);
        chk("rst_after_busy", 32'(busy), 0);
        chk("rst_after_done", 32'(pu_done), 0);
        tick();
        #1;
        chk("rst_after2_done", 32'(pu_done), 0);
        chk("rst_after2_rd", 32'(rd_req), 0);
        pu_req_valid = 2'b11;
        #1;
        chk("rst_regrant", 32'(pu_req_ready), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
